// File: rtl/buffer_pkg.sv
// Shared defaults and helpers for the word-granular buffer controller.
// Geometry here is the reference configuration; instances may override it.
package buffer_pkg;

  localparam int MEM_SIZE_DEF  = 8;
  localparam int PAR_WRITE_DEF = 4;
  localparam int PAR_READ_DEF  = 2;
  localparam int ADDR_W_DEF    = $clog2(MEM_SIZE_DEF);
  localparam int CNT_W_DEF     = $clog2(MEM_SIZE_DEF + 1);

  // True when an access of 'par' words tiles memory of 'mem' words exactly.
  function automatic bit par_tiles(int mem, int par);
    return (par > 0) && (par <= mem) && ((mem % par) == 0);
  endfunction

endpackage

// File: rtl/buffer_if.sv
// Handshake and buffer-addressing bundle between controller, producer/consumer and RAM.
// Width parameters must match the controller instance they connect to.
interface buffer_if #(
  parameter int ADDRES_SIZE = buffer_pkg::ADDR_W_DEF,
  parameter int CNT_SIZE    = buffer_pkg::CNT_W_DEF
);

  logic                   in_valid;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic                   wen;
  logic [ADDRES_SIZE-1:0] waddr;
  logic [ADDRES_SIZE-1:0] raddr;
  logic [CNT_SIZE-1:0]    count;
  logic                   full;
  logic                   empty;

  modport slave (
    input  in_valid, out_ready,
    output in_ready, out_valid, wen, waddr, raddr, count, full, empty
  );

  modport master (
    output in_valid, out_ready,
    input  in_ready, out_valid, wen, waddr, raddr, count, full, empty
  );

endinterface

// File: rtl/buffer_ptr.sv
// Circular base-address pointer: advances by STEP modulo MODULUS, clr wins over adv.
// MODULUS is a multiple of STEP, so a wrap always lands exactly on zero.
module buffer_ptr #(
  parameter int ADDR_W  = buffer_pkg::ADDR_W_DEF,
  parameter int STEP    = buffer_pkg::PAR_WRITE_DEF,
  parameter int MODULUS = buffer_pkg::MEM_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              clr,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W:0] STEP_W = (ADDR_W + 1)'(STEP);
  localparam logic [ADDR_W:0] MOD_W  = (ADDR_W + 1)'(MODULUS);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W:0]   sum;
  logic [ADDR_W:0]   wrapped;

  always_comb begin
    sum     = {1'b0, ptr_q} + STEP_W;
    wrapped = (sum >= MOD_W) ? (sum - MOD_W) : sum;
    ptr_d   = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = wrapped[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/buffer_ctrl.sv
// Occupancy tracking and handshake for a RAM written PAR_WRITE words and read PAR_READ words at a time.
// Address pointers live in two buffer_ptr instances; count and flags are kept here.
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int MEM_SIZE    = MEM_SIZE_DEF,
  parameter int PAR_WRITE   = PAR_WRITE_DEF,
  parameter int PAR_READ    = PAR_READ_DEF,
  parameter int ADDRES_SIZE = $clog2(MEM_SIZE),
  parameter int CNT_SIZE    = $clog2(MEM_SIZE + 1)
) (
  input logic      clk,
  input logic      rst_n,
  input logic      flush,
  buffer_if.slave  bus
);

  if (!par_tiles(MEM_SIZE, PAR_WRITE)) begin : g_bad_par_write
    $error("buffer_ctrl: MEM_SIZE must be a multiple of PAR_WRITE");
  end
  if (!par_tiles(MEM_SIZE, PAR_READ)) begin : g_bad_par_read
    $error("buffer_ctrl: MEM_SIZE must be a multiple of PAR_READ");
  end

  localparam logic [CNT_SIZE-1:0] MEM_C    = CNT_SIZE'(MEM_SIZE);
  localparam logic [CNT_SIZE-1:0] PW_C     = CNT_SIZE'(PAR_WRITE);
  localparam logic [CNT_SIZE-1:0] PR_C     = CNT_SIZE'(PAR_READ);
  localparam logic [CNT_SIZE-1:0] WR_LIMIT = CNT_SIZE'(MEM_SIZE - PAR_WRITE);

  logic [CNT_SIZE-1:0]    count_q;
  logic [CNT_SIZE-1:0]    count_d;
  logic                   in_ready;
  logic                   out_valid;
  logic                   wr_acc;
  logic                   rd_acc;
  logic [ADDRES_SIZE-1:0] waddr;
  logic [ADDRES_SIZE-1:0] raddr;

  // Free space >= PAR_WRITE is written as count <= MEM_SIZE-PAR_WRITE to avoid a subtract.
  always_comb begin
    in_ready  = !flush && (count_q <= WR_LIMIT);
    out_valid = !flush && (count_q >= PR_C);
    wr_acc    = bus.in_valid && in_ready;
    rd_acc    = bus.out_ready && out_valid;
    count_d   = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      if (wr_acc) count_d = count_d + PW_C;
      if (rd_acc) count_d = count_d - PR_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  buffer_ptr #(
    .ADDR_W  (ADDRES_SIZE),
    .STEP    (PAR_WRITE),
    .MODULUS (MEM_SIZE)
  ) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (wr_acc),
    .clr   (flush),
    .ptr   (waddr)
  );

  buffer_ptr #(
    .ADDR_W  (ADDRES_SIZE),
    .STEP    (PAR_READ),
    .MODULUS (MEM_SIZE)
  ) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (rd_acc),
    .clr   (flush),
    .ptr   (raddr)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.wen       = wr_acc;
  assign bus.waddr     = waddr;
  assign bus.raddr     = raddr;
  assign bus.count     = count_q;
  assign bus.full      = (count_q == MEM_C);
  assign bus.empty     = (count_q == '0);

endmodule

// File: tb/tb_buffer_ctrl.sv
// Directed bench for buffer_ctrl at MEM_SIZE=8, PAR_WRITE=4, PAR_READ=2.
module tb_buffer_ctrl;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_checks;
  int   n_errors;

  buffer_if #(.ADDRES_SIZE(3), .CNT_SIZE(4)) bus ();

  buffer_ctrl #(
    .MEM_SIZE  (8),
    .PAR_WRITE (4),
    .PAR_READ  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input int wa, input int ra);
    chk({tag, ".count"}, int'(bus.count), cnt);
    chk({tag, ".waddr"}, int'(bus.waddr), wa);
    chk({tag, ".raddr"}, int'(bus.raddr), ra);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    // outputs while held in reset
    chk("rst.wen", int'(bus.wen), 0);
    chk("rst.in_ready", int'(bus.in_ready), 1);
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.empty", int'(bus.empty), 1);
    chk("rst.full", int'(bus.full), 0);
    rst_n = 1'b1;
    step();
    chk_state("rel", 0, 0, 0);
    chk("rel.empty", int'(bus.empty), 1);
    chk("rel.in_ready", int'(bus.in_ready), 1);
    chk("rel.out_valid", int'(bus.out_valid), 0);

    // two writes fill the buffer, a third is refused
    bus.in_valid = 1'b1;
    #1;
    chk("wr1.wen", int'(bus.wen), 1);
    step();
    chk_state("wr1", 4, 4, 0);
    chk("wr2.wen", int'(bus.wen), 1);
    chk("wr1.out_valid", int'(bus.out_valid), 1);
    step();
    chk_state("wr2", 8, 0, 0);
    chk("wr2.full", int'(bus.full), 1);
    chk("wr2.in_ready", int'(bus.in_ready), 0);
    chk("wr3.wen", int'(bus.wen), 0);
    step();
    chk_state("wr3", 8, 0, 0);
    bus.in_valid = 1'b0;

    // drain with four reads, then one more attempt on an empty buffer
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("rd%0d.raddr", i), int'(bus.raddr), (2 * i) % 8);
      chk($sformatf("rd%0d.count", i), int'(bus.count), 8 - 2 * i);
    end
    chk("rd.out_valid", int'(bus.out_valid), 0);
    chk("rd.empty", int'(bus.empty), 1);
    step();
    chk_state("rd_empty", 0, 0, 0);
    bus.out_ready = 1'b0;

    // count=4, waddr=4, raddr=0, then simultaneous write and read
    bus.in_valid = 1'b1;
    step();
    chk_state("pre_sim", 4, 4, 0);
    bus.out_ready = 1'b1;
    #1;
    chk("sim.wen", int'(bus.wen), 1);
    chk("sim.out_valid", int'(bus.out_valid), 1);
    step();
    chk_state("sim", 6, 0, 2);

    // flush beats both handshakes
    flush = 1'b1;
    #1;
    chk("fl.wen", int'(bus.wen), 0);
    chk("fl.in_ready", int'(bus.in_ready), 0);
    chk("fl.out_valid", int'(bus.out_valid), 0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk_state("fl", 0, 0, 0);
    chk("fl.empty", int'(bus.empty), 1);

    // rebuild count=6 (waddr=0, raddr=2) then reset between edges
    bus.in_valid = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk_state("pre_ar", 6, 0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("ar", 0, 0, 0);
    chk("ar.in_ready", int'(bus.in_ready), 1);
    chk("ar.out_valid", int'(bus.out_valid), 0);
    step();
    rst_n = 1'b1;
    step();
    chk_state("ar_rel", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
